// File: rtl/datasink_pkg.sv
// datasink_pkg: types and constants shared by the datasink capture block
// and its LFSR backpressure generator.
//   state_t   : capture FSM states
//   LFSR_SEED : value loaded on reset and on every accepted arm
//   LFSR_TAPS : Fibonacci tap mask, taps 16,14,13,11 (bit n-1 for tap n)
package datasink_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    FULL    = 2'd2
  } state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/lfsr16.sv
// lfsr16: 16-bit Fibonacci LFSR used to generate pseudo-random backpressure.
//   clk   in  : clock, rising edge
//   reset in  : asynchronous active-high, loads LFSR_SEED
//   load  in  : synchronous reload of LFSR_SEED (has priority over en)
//   en    in  : advance one step
//   q     out : current LFSR state
module lfsr16
  import datasink_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        en,
  output logic [15:0] q
);

  // Shift left; the parity of the tapped bits enters at bit 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= LFSR_SEED;
    end else if (load) begin
      q <= LFSR_SEED;
    end else if (en) begin
      q <= {q[14:0], ^(q & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/datasink.sv
// datasink: consuming end of an AXI-stream of samples. Captures xL samples
// into an internal RAM, owns tready (optionally throttled by an LFSR), and
// reports count, checksum and done. A registered read port allows dumping
// the buffer in any state.
//   clk, reset           : clock and asynchronous active-high reset
//   arm                  : pulse, starts/restarts a capture (ignored in CAPTURE)
//   stall_en             : enable LFSR backpressure
//   tvalid, tdata        : upstream stream
//   tready               : registered ready
//   done                 : registered, high in FULL
//   count                : samples captured since last arm (0..xL)
//   checksum             : zero-extended sample sum mod 2^32
//   rd_addr, rd_data     : read-back port, 1-cycle latency, read-before-write
module datasink
  import datasink_pkg::*;
#(
  parameter int xL = 2048,
  parameter int DW = 16,
  parameter int AW = $clog2(xL)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          arm,
  input  logic          stall_en,
  input  logic          tvalid,
  input  logic [DW-1:0] tdata,
  output logic          tready,
  output logic          done,
  output logic [AW:0]   count,
  output logic [31:0]   checksum,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  localparam logic [AW:0] LAST = (AW + 1)'(xL - 1);

  state_t        state_q;
  state_t        state_d;
  logic          tready_d;
  logic          xfer;
  logic          arm_ok;
  logic [15:0]   lfsr_q;
  logic [DW-1:0] mem [xL];

  assign xfer   = tvalid && tready;
  assign arm_ok = arm && (state_q != CAPTURE);

  lfsr16 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .load  (arm_ok),
    .en    (state_q == CAPTURE),
    .q     (lfsr_q)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (arm) state_d = CAPTURE;
      CAPTURE: if (xfer && (count == LAST)) state_d = FULL;
      FULL:    if (arm) state_d = CAPTURE;
      default: state_d = IDLE;
    endcase
    // Looking at the next state drops tready on the cycle right after the
    // final transfer, so no extra sample can slip in.
    tready_d = (state_d == CAPTURE) && !(stall_en && lfsr_q[0]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      tready   <= 1'b0;
      done     <= 1'b0;
      count    <= '0;
      checksum <= '0;
    end else begin
      state_q <= state_d;
      tready  <= tready_d;
      done    <= (state_d == FULL);
      if (arm_ok) begin
        count    <= '0;
        checksum <= '0;
      end else if (xfer) begin
        count    <= count + 1'b1;
        checksum <= checksum + {{(32 - DW){1'b0}}, tdata};
      end
    end
  end

  // Buffer RAM: write port has no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (xfer) begin
      mem[count[AW-1:0]] <= tdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: tb/tb_datasink.sv
module tb_datasink;

  localparam int XL = 2048;
  localparam int AW = 11;
  localparam logic [15:0] SEED = 16'hACE1;

  logic          clk;
  logic          reset;
  logic          arm;
  logic          stall_en;
  logic          tvalid;
  logic [15:0]   tdata;
  logic          tready;
  logic          done;
  logic [AW:0]   count;
  logic [31:0]   checksum;
  logic [AW-1:0] rd_addr;
  logic [15:0]   rd_data;

  datasink #(.xL(XL), .DW(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .arm      (arm),
    .stall_en (stall_en),
    .tvalid   (tvalid),
    .tdata    (tdata),
    .tready   (tready),
    .done     (done),
    .count    (count),
    .checksum (checksum),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: a sink that is idle, capturing, or full.
  int          m_phase;   // 0 idle, 1 capturing, 2 full
  logic [15:0] m_lfsr;
  bit          m_tready;
  bit          m_done;
  bit          m_xfer;
  int          m_count;
  logic [31:0] m_sum;
  logic [15:0] m_rd;
  logic [15:0] m_mem [XL];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    logic fb;
    fb = s[15] ^ s[13] ^ s[12] ^ s[10];
    return {s[14:0], fb};
  endfunction

  task automatic model_reset();
    m_phase  = 0;
    m_lfsr   = SEED;
    m_tready = 0;
    m_done   = 0;
    m_count  = 0;
    m_sum    = '0;
    m_rd     = '0;
  endtask

  // Applies the sink's rules for one rising edge with the present inputs.
  task automatic model_step();
    int nphase;
    bit accept;
    m_xfer = (tvalid === 1'b1) && m_tready;
    m_rd   = m_mem[rd_addr];
    if (m_xfer) begin
      m_mem[m_count] = tdata;
      m_count++;
      m_sum = m_sum + 32'(tdata);
    end
    accept = (arm === 1'b1) && (m_phase != 1);
    nphase = m_phase;
    if (accept) begin
      nphase  = 1;
      m_count = 0;
      m_sum   = '0;
    end else if (m_phase == 1 && m_count == XL) begin
      nphase = 2;
    end
    m_tready = (nphase == 1) && !((stall_en === 1'b1) && m_lfsr[0]);
    if (accept) m_lfsr = SEED;
    else if (m_phase == 1) m_lfsr = lfsr_next(m_lfsr);
    m_phase = nphase;
    m_done  = (nphase == 2);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("tready", 32'(tready), 32'(m_tready));
    check("done", 32'(done), 32'(m_done));
    check("count", 32'(count), 32'(m_count));
    check("checksum", checksum, m_sum);
  endtask

  task automatic apply_reset();
    reset    = 1'b1;
    arm      = 1'b0;
    tvalid   = 1'b0;
    stall_en = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Arms the sink and streams until full; data either 0,1,2,... or random,
  // tvalid either steady or random (held once asserted until accepted).
  task automatic stream(input bit stall, input bit rnd_valid, input bit rnd_data);
    int idx;
    int cyc;
    logic [15:0] cur;
    idx = 0;
    cyc = 0;
    cur = rnd_data ? 16'($urandom) : 16'(0);
    stall_en = stall;
    tvalid   = 1'b0;
    arm      = 1'b1;
    tick();
    arm = 1'b0;
    if (!stall) check("arm_tready", 32'(tready), 32'd1);
    while (!m_done && cyc < XL * 8) begin
      if (!(tvalid === 1'b1))
        tvalid = rnd_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
      tdata = cur;
      tick();
      cyc++;
      if (m_xfer) begin
        idx++;
        cur = rnd_data ? 16'($urandom) : 16'(idx);
        if (rnd_valid) tvalid = ($urandom_range(0, 3) != 0);
      end
    end
    check("capture_done", 32'(done), 32'd1);
    check("final_count", 32'(count), 32'(XL));
    check("xfers", 32'(idx), 32'(XL));
  endtask

  task automatic readback(input bit seq);
    for (int k = 0; k < XL; k++) begin
      rd_addr = AW'(k);
      tick();
      check("rd_model", 32'(rd_data), 32'(m_rd));
      if (seq) check("rd_seq", 32'(rd_data), 32'(k));
    end
  endtask

  initial begin
    for (int i = 0; i < XL; i++) m_mem[i] = '0;
    reset    = 1'b1;
    arm      = 1'b0;
    stall_en = 1'b0;
    tvalid   = 1'b0;
    tdata    = '0;
    rd_addr  = '0;
    apply_reset();
    check("rst_tready", 32'(tready), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_checksum", checksum, 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);

    // Ramp without backpressure.
    stream(1'b0, 1'b0, 1'b0);
    check("ramp_checksum", checksum, 32'd2096128);
    tvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("full_count", 32'(count), 32'(XL));
      check("full_tready", 32'(tready), 32'd0);
    end
    readback(1'b1);

    // Re-arm from FULL: counters clear, memory survives.
    tvalid = 1'b0;
    arm    = 1'b1;
    tick();
    arm = 1'b0;
    check("rearm_count", 32'(count), 32'd0);
    check("rearm_checksum", checksum, 32'd0);
    check("rearm_tready", 32'(tready), 32'd1);
    rd_addr = AW'(7);
    tick();
    check("rearm_old_mem", 32'(rd_data), 32'd7);

    // Same ramp with LFSR backpressure.
    apply_reset();
    stream(1'b1, 1'b0, 1'b0);
    check("stall_checksum", checksum, 32'd2096128);
    readback(1'b1);

    // Random data and random tvalid with backpressure.
    apply_reset();
    stream(1'b1, 1'b1, 1'b1);
    tvalid = 1'b0;
    for (int i = 0; i < 64; i++) begin
      rd_addr = AW'($urandom_range(0, XL - 1));
      tick();
      check("rnd_rd", 32'(rd_data), 32'(m_rd));
    end

    // 16'hFFFF with tvalid 1,0,1: exactly two transfers.
    apply_reset();
    arm = 1'b1;
    tick();
    arm   = 1'b0;
    tdata = 16'hFFFF;
    tvalid = 1'b1; tick();
    tvalid = 1'b0; tick();
    tvalid = 1'b1; tick();
    tvalid = 1'b0; tick();
    check("ffff_count", 32'(count), 32'd2);
    check("ffff_checksum", checksum, 32'h0001FFFE);

    // Asynchronous reset after 100 transfers.
    apply_reset();
    arm = 1'b1;
    tick();
    arm    = 1'b0;
    tvalid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tdata = 16'(i + 3);
      tick();
    end
    check("pre_reset_count", 32'(count), 32'd100);
    #3;
    reset = 1'b1;
    model_reset();
    #1;
    check("async_tready", 32'(tready), 32'd0);
    check("async_count", 32'(count), 32'd0);
    check("async_checksum", checksum, 32'd0);
    check("async_done", 32'(done), 32'd0);
    #2;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("idle_tready", 32'(tready), 32'd0);
    end
    arm = 1'b1;
    tick();
    arm = 1'b0;
    check("post_reset_arm", 32'(tready), 32'd1);
    tick();
    check("post_reset_xfer", 32'(count), 32'd1);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
